// File: rtl/calc_serial_pkg.sv
// calc_serial_pkg: shared state encoding and widths for the serial window accumulator
package calc_serial_pkg;
  localparam int WIN_MAX = 256;
  localparam int CNT_W = 9;
  localparam int SUM_W = 11;
  localparam int SUM2_W = 14;
  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DONE} state_t;
endpackage

// File: rtl/calc_serial_window_ctrl_if.sv
// calc_serial_window_ctrl_if: window request, sample stream and result handshake bundle
interface calc_serial_window_ctrl_if #(parameter int CNT_W = calc_serial_pkg::CNT_W);
  import calc_serial_pkg::*;
  logic start;
  logic [CNT_W-1:0] win_len;
  logic abort;
  logic [2:0] din;
  logic din_valid;
  logic din_ready;
  logic busy;
  logic res_valid;
  logic res_ready;
  logic [SUM_W-1:0] res_sum;
  logic [SUM2_W-1:0] res_sum2;
  logic [CNT_W-1:0] res_len;
  modport master (
    output start, win_len, abort, din, din_valid, res_ready,
    input din_ready, busy, res_valid, res_sum, res_sum2, res_len
  );
  modport slave (
    input start, win_len, abort, din, din_valid, res_ready,
    output din_ready, busy, res_valid, res_sum, res_sum2, res_len
  );
endinterface

// File: rtl/calc_serial_windowcalc.sv
// calc_serial_windowcalc: running sum and sum-of-squares of 3-bit samples, async active-low clear
module calc_serial_windowcalc import calc_serial_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wable,
  input  logic [2:0]        wdata,
  output logic [SUM_W-1:0]  sum,
  output logic [SUM2_W-1:0] sum2
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum <= '0;
      sum2 <= '0;
    end else if (wable) begin
      sum <= sum + SUM_W'(wdata);
      sum2 <= sum2 + SUM2_W'(wdata) * SUM2_W'(wdata);
    end
endmodule

// File: rtl/calc_serial_window_ctrl.sv
// calc_serial_window_ctrl: runs one accumulator window per start and presents the result via valid/ready
module calc_serial_window_ctrl #(
  parameter int WIN_MAX = calc_serial_pkg::WIN_MAX,
  parameter int CNT_W = calc_serial_pkg::CNT_W
) (
  input logic clk,
  input logic reset,
  calc_serial_window_ctrl_if.slave bus
);
  import calc_serial_pkg::*;
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(WIN_MAX);
  state_t state;
  logic [CNT_W-1:0] cnt, len;
  logic acc_rst_n, busy, din_ready, res_valid, wable;
  assign wable = bus.din_valid & din_ready;
  assign bus.din_ready = din_ready;
  assign bus.busy = busy;
  assign bus.res_valid = res_valid;
  assign bus.res_len = len;
  // acc_rst_n is a flop so the accumulator's async clear never glitches
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      len <= '0;
      acc_rst_n <= 1'b0;
      busy <= 1'b0;
      din_ready <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      acc_rst_n <= 1'b1;
      case (state)
        IDLE: if (bus.start && bus.win_len != '0) begin
          state <= CLEAR;
          len <= (bus.win_len > LEN_MAX) ? LEN_MAX : bus.win_len;
          cnt <= '0;
          acc_rst_n <= 1'b0;
          busy <= 1'b1;
        end
        CLEAR: begin
          state <= ACCUM;
          din_ready <= 1'b1;
        end
        ACCUM: if (wable) begin
          cnt <= cnt + 1'b1;
          if (cnt == len - 1'b1) begin
            state <= DONE;
            din_ready <= 1'b0;
            res_valid <= 1'b1;
          end
        end
        DONE: if (bus.res_ready) begin
          state <= IDLE;
          res_valid <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (bus.abort && state != IDLE) begin
        state <= IDLE;
        busy <= 1'b0;
        din_ready <= 1'b0;
        res_valid <= 1'b0;
      end
    end
  calc_serial_windowcalc u_calc (
    .clk(clk),
    .rst_n(acc_rst_n),
    .wable(wable),
    .wdata(bus.din),
    .sum(bus.res_sum),
    .sum2(bus.res_sum2)
  );
endmodule

// File: tb/tb_calc_serial_window_ctrl.sv
// tb_calc_serial_window_ctrl: scoreboard bench for the window sequencer
module tb_calc_serial_window_ctrl;
  import calc_serial_pkg::*;
  typedef struct {int sum; int sum2; int len;} res_t;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  calc_serial_window_ctrl_if bus();
  calc_serial_window_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  res_t sb[$];
  res_t cur;
  int samp[$];
  int si;
  int n_cmp = 0, n_err = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_win(int wl);
    res_t e;
    int m = (wl > WIN_MAX) ? WIN_MAX : wl;
    bus.start = 1'b1;
    bus.win_len = wl[CNT_W-1:0];
    tick();
    bus.start = 1'b0;
    si = 0;
    e.sum = 0;
    e.sum2 = 0;
    e.len = m;
    for (int i = 0; i < m; i++) begin
      e.sum += samp[i];
      e.sum2 += samp[i] * samp[i];
    end
    if (m != 0) sb.push_back(e);
  endtask
  task automatic feed(int n, bit gaps);
    int acc = 0;
    int budget = 2000;
    bit t = 1'b1;
    bit ok;
    while (acc < n && budget > 0) begin
      bus.din = samp[si][2:0];
      bus.din_valid = gaps ? t : 1'b1;
      t = ~t;
      @(negedge clk);
      ok = bus.din_ready && bus.din_valid;
      tick();
      if (ok) begin
        si++;
        acc++;
      end
      budget--;
    end
    bus.din_valid = 1'b0;
    if (acc != n) check("feed_timeout", acc, n);
  endtask
  task automatic get_result();
    @(negedge clk);
    check("res_lat", bus.res_valid, 1);
    check("rdy_drop", bus.din_ready, 0);
    check("sb_avail", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check("res_sum", bus.res_sum, cur.sum);
      check("res_sum2", bus.res_sum2, cur.sum2);
      check("res_len", bus.res_len, cur.len);
    end
  endtask
  task automatic consume();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_valid", bus.res_valid, 0);
    tick();
  endtask
  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.win_len = '0;
    bus.abort = 1'b0;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.din_ready, 0);
    check("rst_valid", bus.res_valid, 0);
    check("rst_sum", bus.res_sum, 0);
    check("rst_sum2", bus.res_sum2, 0);
    check("rst_len", bus.res_len, 0);
    reset = 1'b0;
    tick();
    tick();
    // basic window, then hold the result with res_ready low
    samp = '{1, 2, 3, 7};
    start_win(4);
    feed(4, 1'b0);
    get_result();
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", bus.res_valid, 1);
      check("hold_sum", bus.res_sum, cur.sum);
      check("hold_sum2", bus.res_sum2, cur.sum2);
      check("hold_len", bus.res_len, cur.len);
    end
    tick();
    consume();
    // back-to-back window proves the accumulator clear
    samp = '{2, 2, 2};
    start_win(3);
    feed(3, 1'b0);
    get_result();
    consume();
    // full-length window with a toggling valid
    samp.delete();
    for (int i = 0; i < 256; i++) samp.push_back(7);
    start_win(256);
    feed(256, 1'b1);
    get_result();
    consume();
    // zero length is ignored and the old result stays readable
    bus.start = 1'b1;
    bus.win_len = '0;
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    check("zero_busy", bus.busy, 0);
    check("keep_sum", bus.res_sum, 1792);
    tick();
    // oversize length clamps to the maximum
    samp.delete();
    for (int i = 0; i < 300; i++) samp.push_back(int'($urandom_range(0, 7)));
    start_win(300);
    feed(256, 1'b0);
    get_result();
    consume();
    // reset mid-window drops everything
    samp.delete();
    for (int i = 0; i < 20; i++) samp.push_back(3);
    start_win(20);
    feed(10, 1'b0);
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ready", bus.din_ready, 0);
    check("mid_rst_valid", bus.res_valid, 0);
    check("mid_rst_sum", bus.res_sum, 0);
    sb.delete();
    reset = 1'b0;
    tick();
    tick();
    // abort while a result is pending
    samp = '{5, 5};
    start_win(2);
    feed(2, 1'b0);
    get_result();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_valid", bus.res_valid, 0);
    check("abort_busy", bus.busy, 0);
    tick();
    // start during ACCUM must not restart or resize the window
    samp = '{1, 1, 1, 1, 1};
    start_win(5);
    feed(2, 1'b0);
    bus.start = 1'b1;
    bus.win_len = 2;
    tick();
    bus.start = 1'b0;
    feed(3, 1'b0);
    get_result();
    consume();
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/calc_serial_window_ctrl.md
# calc_serial_window_ctrl

Sequencer for the serial window accumulator. Accepts a window length and a start pulse, clears the accumulator, and gates a valid/ready sample stream into it for exactly one window. It then presents the window sum and sum-of-squares behind a valid/ready result handshake. It sits between the 3-bit serial sample source and downstream statistics logic, and owns the accumulator instance.

## Interface
Parameters:
- WIN_MAX, 256: maximum samples per window. 256·7 = 1792 fits 11 bits; 256·49 = 12544 fits 14 bits.
- CNT_W, 9: width of the window-length and sample-count fields.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request a new window; honoured only in IDLE
- win_len  in  CNT_W  samples per window; sampled with start
- abort  in  1  abandon the current window; return to IDLE
- din  in  3  sample value
- din_valid  in  1  sample present
- din_ready  out  1  controller accepts a sample this cycle
- busy  out  1  high in any state other than IDLE
- res_valid  out  1  result available
- res_ready  in  1  downstream consumes the result
- res_sum  out  11  Σ din over the window
- res_sum2  out  14  Σ din² over the window
- res_len  out  CNT_W  number of samples in the window

## Operation
- FSM states: IDLE, CLEAR, ACCUM, DONE.
- IDLE:
  - start=1 and win_len≠0 → CLEAR.
  - Latch len = min(win_len, WIN_MAX).
  - win_len=0 → start is ignored and the FSM stays in IDLE.
- CLEAR: lasts one cycle, then → ACCUM. A registered accumulator clear (acc_rst_n) is low during this cycle.
- ACCUM:
  - din_ready=1.
  - A sample is accepted when din_valid & din_ready. The accumulator then sees wable=1, with wdata=din passed through combinationally, and cnt increments.
  - When the sample accepted has cnt == len−1 → DONE.
  - din_valid low stalls the window with no timeout.
- DONE:
  - res_valid=1.
  - res_sum/res_sum2 are taken directly from the accumulator outputs, which are stable because wable=0.
  - res_len = len.
  - res_valid & res_ready → IDLE.
- abort=1 in any state except IDLE → IDLE at the next edge; any pending result is discarded.
- start is ignored outside IDLE, including when it coincides with res_ready in DONE.
- Results remain readable on res_sum/res_sum2 after return to IDLE, until the next CLEAR.
- Clamping win_len to WIN_MAX guarantees no overflow of either sum.
- Reset: state=IDLE, cnt=0, len=0, acc_rst_n=0 (accumulator held clear).
  - Every output is 0 during reset and in the first IDLE cycle.
  - acc_rst_n returns to 1 one edge after reset deasserts.
  - Reset mid-window discards all progress.

## Timing
- start sampled at edge E0 → CLEAR during cycle E0..E1 → ACCUM from E1. Earliest first-sample acceptance is at edge E2.
- Last sample accepted at edge En → res_valid high in the cycle after En, so result latency is 1 cycle.
- Best-case window time = len + 2 cycles from start to res_valid.
- res_valid, once high, stays high until the res_ready edge or abort/reset. res_sum, res_sum2 and res_len do not change while res_valid=1.
- din_ready is a decode of registered state only, with no combinational path from din_valid.
- acc_rst_n is driven from a flop (glitch-free), because it feeds the accumulator's asynchronous active-low reset.

## Structure
- Shared package calc_serial_pkg:
  - state encoding (IDLE/CLEAR/ACCUM/DONE)
  - WIN_MAX and CNT_W
  - sum widths (11, 14)
- One sub-module: calc_serial_windowcalc, instantiated as the datapath.
  - Its reset pin is driven by acc_rst_n.
  - Its wable pin is driven by din_valid & din_ready.
  - Its wdata pin is driven by din.
- Everything else (FSM, counter, len register) lives in a single file.

## Test plan
- Reset, then start with win_len=4 and din 1,2,3,7 on consecutive cycles → res_valid one cycle after the 4th acceptance, res_sum=13, res_sum2=63, res_len=4. Hold res_ready=0 for 5 cycles → values stable; pulse res_ready → busy=0 next cycle.
- win_len=256, all din=7, din_valid toggling 1/0 → exactly 256 acceptances, res_sum=1792, res_sum2=12544.
- Back-to-back windows: after the first window, start with win_len=3 and din=2,2,2 → res_sum=6, res_sum2=12 (proves CLEAR).
- win_len=0 with start → busy stays 0. win_len=300 → res_len=256, and din_ready drops after the 256th sample.
- Reset asserted after 10 samples in ACCUM → next cycle busy=0, din_ready=0, res_valid=0; res_sum reads 0 one cycle after reset.
- abort in DONE with res_ready=0 → IDLE next cycle, res_valid=0. start pulsed during ACCUM → ignored; window length unchanged.
